// File: rtl/intrapred_pkg.sv
// Shared definitions for the intra prediction mode decider.
//   mode_e  : H.264-style 4x4 intra prediction mode indices
//   state_e : decider FSM states
//   sad_w() : width of a full-block SAD accumulator
package intrapred_pkg;

   typedef enum logic [3:0] {
      MODE_V   = 4'd0,
      MODE_H   = 4'd1,
      MODE_DC  = 4'd2,
      MODE_DDL = 4'd3,
      MODE_DDR = 4'd4,
      MODE_VR  = 4'd5,
      MODE_HD  = 4'd6,
      MODE_VL  = 4'd7,
      MODE_HU  = 4'd8
   } mode_e;

   typedef enum logic [1:0] {
      ST_ACCUM  = 2'd0,
      ST_DECIDE = 2'd1,
      ST_HOLD   = 2'd2
   } state_e;

   // BLK_W*BLK_W pixels of at most 2^PIX_BITS-1 each: the sum fits in
   // PIX_BITS + 2*log2(BLK_W) bits.
   function automatic int sad_w(input int pix_bits, input int blk_w);
      return pix_bits + 2 * $clog2(blk_w);
   endfunction

endpackage

// File: rtl/intrapred_mode_decider_sad_row.sv
// sad_row: sum of absolute differences between one row of original pixels
// and the same row as predicted by one mode.
//   orig    : BLK_W pixels, pixel 0 in the LSBs
//   pred    : BLK_W predicted pixels, same layout
//   row_sad : sum over the row of |orig - pred|
module sad_row #(
   parameter int BLK_W    = 4,
   parameter int PIX_BITS = 8,
   localparam int ROW_W   = PIX_BITS + $clog2(BLK_W)
) (
   input  logic [BLK_W*PIX_BITS-1:0] orig,
   input  logic [BLK_W*PIX_BITS-1:0] pred,
   output logic [ROW_W-1:0]          row_sad
);

   logic [PIX_BITS-1:0] a;
   logic [PIX_BITS-1:0] b;

   always_comb begin
      row_sad = '0;
      a       = '0;
      b       = '0;
      for (int i = 0; i < BLK_W; i++) begin
         a       = orig[i*PIX_BITS +: PIX_BITS];
         b       = pred[i*PIX_BITS +: PIX_BITS];
         row_sad = row_sad + ROW_W'((a > b) ? (a - b) : (b - a));
      end
   end

endmodule

// File: rtl/intrapred_mode_decider.sv
// intrapred_mode_decider: accumulates per-mode SAD over one BLK_W x BLK_W
// block delivered a row per beat, then picks the cheapest enabled mode.
//
// Handshake: a beat/decision transfers on the rising clk edge where
// valid && ready; valid and its payload stay put until that edge.
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   in_valid/in_ready     row beat handshake (ready only in ACCUM)
//   in_orig, in_pred      one original row, same row for every mode
//   in_last               final-row marker (checked against row counter)
//   mode_mask             enabled modes, sampled on the first beat
//   out_valid/out_ready   decision handshake
//   out_mode, out_sad     winning mode and its cost
//   out_none              no mode was enabled
//   err_framing           sticky: in_last disagreed with the row counter
//   dbg_state             current FSM state (state_e encoding)
//   mode_bias             only with INTRAPRED_MODE_BIAS_EN: per-mode cost
//                         offset, sampled with mode_mask, added saturating
module intrapred_mode_decider
   import intrapred_pkg::*;
#(
   parameter int BLK_W     = 4,
   parameter int NUM_MODES = 9,
   parameter int PIX_BITS  = 8
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic                                  in_valid,
   output logic                                  in_ready,
   input  logic [BLK_W*PIX_BITS-1:0]             in_orig,
   input  logic [NUM_MODES*BLK_W*PIX_BITS-1:0]   in_pred,
   input  logic                                  in_last,
   input  logic [NUM_MODES-1:0]                  mode_mask,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   output logic [3:0]                            out_mode,
   output logic [PIX_BITS+2*$clog2(BLK_W)-1:0]   out_sad,
   output logic                                  out_none,
   output logic                                  err_framing,
   output logic [1:0]                            dbg_state
`ifdef INTRAPRED_MODE_BIAS_EN
   ,
   input  logic [NUM_MODES*(PIX_BITS+2*$clog2(BLK_W))-1:0] mode_bias
`endif
);

   localparam int SAD_W = sad_w(PIX_BITS, BLK_W);
   localparam int ROW_W = PIX_BITS + $clog2(BLK_W);
   localparam int CNT_W = $clog2(BLK_W);
   localparam logic [CNT_W-1:0] LAST_ROW  = CNT_W'(BLK_W - 1);
   localparam logic [3:0]       LAST_MODE = 4'(NUM_MODES - 1);
   localparam logic [SAD_W-1:0] SAD_MAX   = '1;

   state_e               state;
   state_e               state_nxt;
   logic [CNT_W-1:0]     row_cnt;
   logic [3:0]           idx;
   logic [NUM_MODES-1:0] mask_q;
   logic [SAD_W-1:0]     acc     [NUM_MODES];
   logic [ROW_W-1:0]     row_sad [NUM_MODES];
   logic [SAD_W-1:0]     best_sad;
   logic [3:0]           best_mode;
   logic                 found;
   logic [SAD_W-1:0]     cost;
   logic                 accept;
   logic                 first_row;
   logic                 last_row;

   assign accept    = in_valid && in_ready;
   assign first_row = (row_cnt == '0);
   assign last_row  = (row_cnt == LAST_ROW);

   for (genvar m = 0; m < NUM_MODES; m++) begin : g_row
      sad_row #(
         .BLK_W    (BLK_W),
         .PIX_BITS (PIX_BITS)
      ) u_sad_row (
         .orig    (in_orig),
         .pred    (in_pred[m*BLK_W*PIX_BITS +: BLK_W*PIX_BITS]),
         .row_sad (row_sad[m])
      );
   end

   // Cost of the mode under examination in DECIDE.
`ifdef INTRAPRED_MODE_BIAS_EN
   logic [NUM_MODES*SAD_W-1:0] bias_q;
   logic [SAD_W:0]             biased;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bias_q <= '0;
      end else if (accept && first_row) begin
         bias_q <= mode_bias;
      end
   end

   always_comb begin
      biased = {1'b0, acc[idx]} + {1'b0, bias_q[idx*SAD_W +: SAD_W]};
      cost   = biased[SAD_W] ? SAD_MAX : biased[SAD_W-1:0];
   end
`else
   assign cost = acc[idx];
`endif

   // FSM: state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_ACCUM;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM: next state. The block ends on the row counter, never on in_last.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_ACCUM:  if (accept && last_row) state_nxt = ST_DECIDE;
         ST_DECIDE: if (idx == LAST_MODE)   state_nxt = ST_HOLD;
         ST_HOLD:   if (out_ready)          state_nxt = ST_ACCUM;
         default:   state_nxt = ST_ACCUM;
      endcase
   end

   // FSM: outputs
   always_comb begin
      in_ready  = (state == ST_ACCUM);
      out_valid = (state == ST_HOLD);
      out_none  = (state == ST_HOLD) && !found;
   end

   assign out_mode  = best_mode;
   assign out_sad   = best_sad;
   assign dbg_state = state;

   // Per-mode accumulators: the first row of a block loads, later rows add.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int m = 0; m < NUM_MODES; m++) acc[m] <= '0;
      end else if (accept) begin
         for (int m = 0; m < NUM_MODES; m++) begin
            acc[m] <= first_row ? SAD_W'(row_sad[m]) : acc[m] + SAD_W'(row_sad[m]);
         end
      end
   end

   // Row counting, framing check and the sequential minimum search.
   // The search starts from "nothing found, cost all ones, mode 0", which is
   // exactly the answer reported when every mode is masked.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         row_cnt     <= '0;
         mask_q      <= '0;
         err_framing <= 1'b0;
         idx         <= '0;
         best_sad    <= '0;
         best_mode   <= '0;
         found       <= 1'b0;
      end else begin
         if (accept) begin
            row_cnt <= last_row ? '0 : row_cnt + CNT_W'(1);
            if (first_row) mask_q <= mode_mask;
            if (in_last != last_row) err_framing <= 1'b1;
            if (last_row) begin
               best_sad  <= SAD_MAX;
               best_mode <= '0;
               found     <= 1'b0;
            end
         end
         if (state == ST_DECIDE) begin
            idx <= (idx == LAST_MODE) ? '0 : idx + 4'd1;
            // Strictly smaller wins, so ties keep the lower index.
            if (mask_q[idx] && (!found || cost < best_sad)) begin
               best_sad  <= cost;
               best_mode <= idx;
               found     <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_intrapred_mode_decider.sv
// Bench for intrapred_mode_decider: directed and random blocks on a 4x4
// instance checked against a reference model, plus one 16x16 worst-case
// SAD block on a second instance.
module tb_intrapred_mode_decider;

   localparam int BW = 4;
   localparam int NM = 9;
   localparam int PB = 8;
   localparam int SW = 12;
   localparam int BW16 = 16;
   localparam int SW16 = 16;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   // ---------------- 4x4 DUT ----------------
   logic                    in_valid  = 1'b0;
   logic                    in_ready;
   logic [BW*PB-1:0]        in_orig   = '0;
   logic [NM*BW*PB-1:0]     in_pred   = '0;
   logic                    in_last   = 1'b0;
   logic [NM-1:0]           mode_mask = '0;
   logic                    out_valid;
   logic                    out_ready = 1'b0;
   logic [3:0]              out_mode;
   logic [SW-1:0]           out_sad;
   logic                    out_none;
   logic                    err_framing;
   logic [1:0]              dbg_state;

   intrapred_mode_decider #(.BLK_W(BW), .NUM_MODES(NM), .PIX_BITS(PB)) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_orig     (in_orig),
      .in_pred     (in_pred),
      .in_last     (in_last),
      .mode_mask   (mode_mask),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_mode    (out_mode),
      .out_sad     (out_sad),
      .out_none    (out_none),
      .err_framing (err_framing),
      .dbg_state   (dbg_state)
`ifdef INTRAPRED_MODE_BIAS_EN
      ,
      .mode_bias   ('0)
`endif
   );

   // ---------------- 16x16 DUT ----------------
   logic                    v16     = 1'b0;
   logic                    rdy16;
   logic [BW16*PB-1:0]      orig16  = '0;
   logic [NM*BW16*PB-1:0]   pred16  = '0;
   logic                    last16  = 1'b0;
   logic [NM-1:0]           mask16  = '0;
   logic                    ov16;
   logic                    or16    = 1'b0;
   logic [3:0]              mode16;
   logic [SW16-1:0]         sad16;
   logic                    none16;
   logic                    err16;
   logic [1:0]              dbg16;

   intrapred_mode_decider #(.BLK_W(BW16), .NUM_MODES(NM), .PIX_BITS(PB)) dut16 (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (v16),
      .in_ready    (rdy16),
      .in_orig     (orig16),
      .in_pred     (pred16),
      .in_last     (last16),
      .mode_mask   (mask16),
      .out_valid   (ov16),
      .out_ready   (or16),
      .out_mode    (mode16),
      .out_sad     (sad16),
      .out_none    (none16),
      .err_framing (err16),
      .dbg_state   (dbg16)
`ifdef INTRAPRED_MODE_BIAS_EN
      ,
      .mode_bias   ('0)
`endif
   );

   // ---------------- scoreboard state ----------------
   int n_assert = 0;
   int n_fail   = 0;

   int          blk_orig [BW][BW];
   int          blk_pred [NM][BW][BW];
   logic [NM-1:0] blk_mask;
   logic        exp_err = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference: cost of each enabled mode, then the smallest cost, then the
   // lowest index carrying it.
   task automatic ref_decide(output int e_mode, output int e_sad, output int e_none);
      int costs [NM];
      int min_c;
      for (int m = 0; m < NM; m++) begin
         costs[m] = 0;
         for (int r = 0; r < BW; r++)
            for (int c = 0; c < BW; c++) begin
               int d;
               d = blk_orig[r][c] - blk_pred[m][r][c];
               costs[m] += (d < 0) ? -d : d;
            end
      end
      e_mode = 0;
      e_sad  = (1 << SW) - 1;
      e_none = (blk_mask == '0) ? 1 : 0;
      if (e_none == 0) begin
         min_c = 1 << 30;
         for (int m = 0; m < NM; m++) if (blk_mask[m] && costs[m] < min_c) min_c = costs[m];
         for (int m = NM - 1; m >= 0; m--) if (blk_mask[m] && costs[m] == min_c) e_mode = m;
         e_sad = min_c;
      end
   endtask

   task automatic fill_random(input int kind);
      for (int r = 0; r < BW; r++)
         for (int c = 0; c < BW; c++) begin
            blk_orig[r][c] = $urandom_range(0, 254);
            for (int m = 0; m < NM; m++)
               blk_pred[m][r][c] = (kind == 0) ? $urandom_range(0, 255)
                                               : blk_orig[r][c] + $urandom_range(0, 1);
         end
   endtask

   // Drive n rows; in_last goes high on row last_at. in_valid is left high.
   task automatic send_rows(input int n, input int last_at);
      for (int r = 0; r < n; r++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_last  = (r == last_at);
         // Only the first beat's mask matters; later beats carry noise.
         mode_mask = (r == 0) ? blk_mask : NM'($urandom_range(0, 511));
         for (int c = 0; c < BW; c++) begin
            in_orig[c*PB +: PB] = 8'(blk_orig[r][c]);
            for (int m = 0; m < NM; m++) in_pred[(m*BW + c)*PB +: PB] = 8'(blk_pred[m][r][c]);
         end
         if ((r == last_at) != (r == BW - 1)) exp_err = 1'b1;
         check("in_ready_accum", {31'd0, in_ready}, 32'd1);
      end
   endtask

   // Latency is counted in cycles from the cycle carrying the last beat to
   // the first cycle with out_valid high.
   task automatic wait_decision(input string tag, input int hold);
      int lat;
      int e_mode, e_sad, e_none;
      ref_decide(e_mode, e_sad, e_none);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         if (lat == 1) begin
            in_valid = 1'b0;
            in_last  = 1'b0;
         end
      end while (!out_valid && lat < 40);
      check({tag, "_latency"}, lat, NM + 1);
      check({tag, "_mode"}, {28'd0, out_mode}, e_mode);
      check({tag, "_sad"},  {20'd0, out_sad},  e_sad);
      check({tag, "_none"}, {31'd0, out_none}, e_none);
      check({tag, "_err"},  {31'd0, err_framing}, {31'd0, exp_err});
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
         check({tag, "_hold_mode"},  {28'd0, out_mode}, e_mode);
         check({tag, "_hold_sad"},   {20'd0, out_sad},  e_sad);
         check({tag, "_hold_none"},  {31'd0, out_none}, e_none);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_ready_after"}, {31'd0, in_ready}, 32'd1);
      check({tag, "_valid_after"}, {31'd0, out_valid}, 32'd0);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_in_ready"},  {31'd0, in_ready},    32'd1);
      check({tag, "_out_valid"}, {31'd0, out_valid},   32'd0);
      check({tag, "_out_mode"},  {28'd0, out_mode},    32'd0);
      check({tag, "_out_sad"},   {20'd0, out_sad},     32'd0);
      check({tag, "_out_none"},  {31'd0, out_none},    32'd0);
      check({tag, "_err"},       {31'd0, err_framing}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      // ---- reset state ----
      repeat (3) @(negedge clk);
      check_reset_values("reset");
      reset = 1'b1;

      // ---- mode 1 exact, others off by one ----
      fill_random(0);
      for (int m = 0; m < NM; m++)
         for (int r = 0; r < BW; r++)
            for (int c = 0; c < BW; c++)
               blk_pred[m][r][c] = (m == 1) ? blk_orig[r][c] : blk_orig[r][c] + 1;
      blk_mask = '1;
      send_rows(BW, BW - 1);
      wait_decision("exact_h", 0);

      // ---- tie between modes 2 and 5 ----
      for (int r = 0; r < BW; r++)
         for (int c = 0; c < BW; c++) begin
            blk_orig[r][c] = $urandom_range(0, 200);
            for (int m = 0; m < NM; m++) blk_pred[m][r][c] = blk_orig[r][c];
         end
      blk_pred[2][0][0] += 7;
      blk_pred[5][3][3] += 7;
      for (int m = 0; m < NM; m++)
         if (m != 2 && m != 5) blk_pred[m][1][2] += 8 + m;
      blk_mask = '1;
      send_rows(BW, BW - 1);
      wait_decision("tie_2_5", 1);

      // ---- all modes masked ----
      fill_random(0);
      blk_mask = '0;
      send_rows(BW, BW - 1);
      wait_decision("none", 2);

      // ---- random blocks ----
      for (int b = 0; b < 16; b++) begin
         fill_random(b % 2);
         blk_mask = NM'($urandom_range(0, 511));
         send_rows(BW, BW - 1);
         wait_decision("random", $urandom_range(0, 3));
      end

      // ---- early in_last: framing error, still decides on the counter ----
      fill_random(0);
      blk_mask = '1;
      send_rows(BW, 1);
      wait_decision("framing", 5);

      // ---- reset in the middle of a block ----
      fill_random(1);
      blk_mask = '1;
      send_rows(2, BW - 1);
      @(negedge clk);
      in_valid = 1'b0;
      #2 reset = 1'b0;
      #1 check_reset_values("mid_reset");
      exp_err = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      fill_random(0);
      blk_mask = NM'($urandom_range(1, 511));
      send_rows(BW, BW - 1);
      wait_decision("after_reset", 1);

      // ---- 16x16 worst case: every pixel differs by 255 ----
      orig16 = '1;
      pred16 = '0;
      for (int r = 0; r < BW16; r++) begin
         @(negedge clk);
         v16    = 1'b1;
         last16 = (r == BW16 - 1);
         mask16 = (r == 0) ? '1 : '0;
         check("blk16_ready", {31'd0, rdy16}, 32'd1);
      end
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         if (lat == 1) begin
            v16    = 1'b0;
            last16 = 1'b0;
         end
      end while (!ov16 && lat < 40);
      check("blk16_latency", lat, NM + 1);
      check("blk16_sad",  {16'd0, sad16}, 32'd65280);
      check("blk16_mode", {28'd0, mode16}, 32'd0);
      check("blk16_none", {31'd0, none16}, 32'd0);
      check("blk16_err",  {31'd0, err16}, 32'd0);
      or16 = 1'b1;
      @(negedge clk);
      or16 = 1'b0;
      check("blk16_ready_after", {31'd0, rdy16}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/intrapred_mode_decider.md
INTRAPRED_MODE_DECIDER -- requirements
Module: intrapred_mode_decider

Interface
REQ-001 SHALL have parameter BLK_W, default 4, block width and height in pixels (legal 4, 8, 16).
REQ-002 SHALL have parameter NUM_MODES, default 9, candidate prediction modes (legal 1..9).
REQ-003 SHALL have parameter PIX_BITS, default 8, unsigned pixel width.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_valid  input  1  row beat valid.
REQ-007 SHALL have port in_ready  output  1  row beat accepted when in_valid && in_ready.
REQ-008 SHALL have port in_orig  input  BLK_W*PIX_BITS  one row of original pixels, pixel 0 in the LSBs.
REQ-009 SHALL have port in_pred  input  NUM_MODES*BLK_W*PIX_BITS  the same row predicted by every mode, mode 0 in the LSBs.
REQ-010 SHALL have port in_last  input  1  marks the final row of a block.
REQ-011 SHALL have port mode_mask  input  NUM_MODES  1 = mode available; sampled on the first beat of a block.
REQ-012 SHALL have port out_valid  output  1  decision valid.
REQ-013 SHALL have port out_ready  input  1  downstream accepts the decision.
REQ-014 SHALL have port out_mode  output  4  winning mode index.
REQ-015 SHALL have port out_sad  output  SAD_W  winning cost, where SAD_W = PIX_BITS + 2*log2(BLK_W).
REQ-016 SHALL have port out_none  output  1  no mode was enabled.
REQ-017 SHALL have port err_framing  output  1  sticky framing error flag.

Function
REQ-018 SHALL use FSM states ACCUM, DECIDE and HOLD; ACCUM is entered at reset.
REQ-019 ACCUM SHALL drive in_ready=1; DECIDE and HOLD SHALL drive in_ready=0.
REQ-020 On each accepted beat, SHALL add sum over pixels of |orig-pred| to each mode's SAD accumulator; accumulator width SHALL be SAD_W, and the sum SHALL never overflow.
REQ-021 The first beat of a block SHALL load the accumulators rather than add to them.
REQ-022 A row counter SHALL count accepted beats 0..BLK_W-1; the block SHALL end when the counter reaches BLK_W-1.
REQ-023 When in_last disagrees with counter==BLK_W-1 on an accepted beat, err_framing SHALL be set until reset; the block SHALL still end on the counter.
REQ-024 DECIDE SHALL examine one mode per cycle in ascending index order, for exactly NUM_MODES cycles, then enter HOLD.
REQ-025 During DECIDE, masked modes SHALL be skipped and a strictly smaller cost SHALL replace the best, so that a tie goes to the lowest index.
REQ-026 HOLD SHALL assert out_valid; out_mode, out_sad and out_none SHALL be stable while out_valid && !out_ready.
REQ-027 out_valid && out_ready SHALL return the FSM to ACCUM; in_ready SHALL be 1 in the next cycle.
REQ-028 Latency SHALL be exactly NUM_MODES+1 cycles from the last accepted beat to out_valid.
REQ-029 If all modes are masked: out_none=1, out_mode=0, out_sad=all ones.

Reset
REQ-030 On reset assertion, all state SHALL clear immediately: in_ready=1 (ACCUM), out_valid=0, out_mode=0, out_sad=0, out_none=0, err_framing=0, row counter=0.
REQ-031 A block in flight at reset SHALL be discarded, and the next accepted beat SHALL be treated as a first row.

Configuration
REQ-032 With INTRAPRED_MODE_BIAS_EN defined, SHALL add input mode_bias (NUM_MODES*SAD_W, sampled with mode_mask) to each SAD before comparison; the cost SHALL saturate at all ones, and out_sad SHALL report the biased cost.
REQ-033 Without INTRAPRED_MODE_BIAS_EN, the mode_bias port SHALL be absent and the cost SHALL be the raw SAD.

Structure
REQ-034 Package intrapred_pkg SHALL hold the mode enum (0 V, 1 H, 2 DC, 3 DDL, 4 DDR, 5 VR, 6 HD, 7 VL, 8 HU), the SAD_W function, and the FSM state typedef.
REQ-035 Sub-module sad_row SHALL compute the abs-diff adder tree for one mode and one row; it SHALL be instantiated NUM_MODES times.

Verification
REQ-036 BLK_W=4, all modes enabled, mode 1 pred = orig, others offset by 1 -> out_mode=1, out_sad=0, out_valid 10 cycles after the last beat.
REQ-037 Modes 2 and 5 both SAD=7 and lowest, all others larger -> out_mode=2.
REQ-038 mode_mask=0 -> out_none=1, out_mode=0, out_sad=all ones.
REQ-039 BLK_W=16, orig=255, pred=0 for all modes -> out_sad=65280 with no overflow.
REQ-040 in_last on row 2 of 4 -> err_framing=1 and the decision still issues after row 4; out_ready held low 5 cycles -> outputs stable.
REQ-041 Reset asserted after 2 beats -> outputs at reset values; a following full block decides correctly.
